rob: RTL and testbench

ROB -- requirements
Module: rob

---
 rtl/rob_pkg.sv | 21 ++
 rtl/rob.sv | 222 ++++++++++++++++++++++
 tb/tb_rob.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared reorder-buffer configuration: default index width, instruction-kind
// encodings and the per-entry payload record.
package rob_pkg;

    localparam int DEF_ROB_SIZE_WIDTH = 3;

    typedef enum logic [1:0] {
        KIND_REG    = 2'b00,
        KIND_STORE  = 2'b01,
        KIND_BRANCH = 2'b10,
        KIND_NOP    = 2'b11
    } kind_e;

    typedef struct packed {
        kind_e       kind;
        logic [4:0]  rd;
        logic [31:0] value;
        logic [31:0] pred_pc;
    } rob_payload_t;

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order allocation and retirement, out-of-order writeback
// from the RS and LSB broadcast buses, operand forwarding and branch flush.
module rob
    import rob_pkg::*;
#(
    parameter int ROB_SIZE_WIDTH = DEF_ROB_SIZE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,

    input  logic                      issue_valid,
    input  logic [4:0]                issue_rd,
    input  logic [1:0]                issue_kind,
    input  logic [31:0]               issue_pred_pc,
    output logic                      rob_full,
    output logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,

    input  logic                      rs_ready,
    input  logic [ROB_SIZE_WIDTH-1:0] rs_rob_id,
    input  logic [31:0]               rs_value,
    input  logic                      lsb_ready,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id,
    input  logic [31:0]               lsb_value,

    input  logic [ROB_SIZE_WIDTH-1:0] query_id1,
    input  logic [ROB_SIZE_WIDTH-1:0] query_id2,
    output logic                      query_ready1,
    output logic                      query_ready2,
    output logic [31:0]               query_value1,
    output logic [31:0]               query_value2,

    output logic                      commit_valid,
    output logic [4:0]                commit_rd,
    output logic [31:0]               commit_value,
    output logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
    output logic                      commit_store,

    output logic                      rob_clear,
    output logic [31:0]               clear_pc,
    output logic [ROB_SIZE_WIDTH-1:0] head_rob_id
);

    localparam int ROB_SIZE = 2 ** ROB_SIZE_WIDTH;
    localparam logic [ROB_SIZE_WIDTH:0] FULL_COUNT = (ROB_SIZE_WIDTH + 1)'(ROB_SIZE);

    typedef logic [ROB_SIZE_WIDTH-1:0] idx_t;

    logic         busy_q  [ROB_SIZE];
    logic         busy_d  [ROB_SIZE];
    logic         ready_q [ROB_SIZE];
    logic         ready_d [ROB_SIZE];
    rob_payload_t entry_q [ROB_SIZE];
    rob_payload_t entry_d [ROB_SIZE];

    idx_t                    head_q, head_d;
    idx_t                    tail_q, tail_d;
    logic [ROB_SIZE_WIDTH:0] count_q, count_d;

    logic        commit_valid_q, commit_valid_d;
    logic        commit_store_q, commit_store_d;
    logic [4:0]  commit_rd_q, commit_rd_d;
    logic [31:0] commit_value_q, commit_value_d;
    idx_t        commit_id_q, commit_id_d;
    logic        clear_q, clear_d;
    logic [31:0] clear_pc_q, clear_pc_d;

    rob_payload_t head_entry;
    logic         rs_hit_head, lsb_hit_head, head_ready;
    logic [31:0]  head_value;
    logic         retire, issue_fire, mispredict;

    // Head readiness sees this cycle's broadcast so a result can retire on the
    // very edge that would otherwise only mark the entry ready.
    assign head_entry   = entry_q[head_q];
    assign rs_hit_head  = rs_ready && (rs_rob_id == head_q);
    assign lsb_hit_head = lsb_ready && (lsb_rob_id == head_q);
    assign head_value   = lsb_hit_head ? lsb_value :
                          rs_hit_head  ? rs_value  : head_entry.value;
    assign head_ready   = ready_q[head_q] || rs_hit_head || lsb_hit_head;
    assign retire       = rdy && !clear_q && busy_q[head_q] && head_ready;
    assign mispredict   = (head_entry.kind == KIND_BRANCH) && (head_value != head_entry.pred_pc);

    assign rob_full     = (count_q == FULL_COUNT);
    assign issue_fire   = issue_valid && !rob_full && rdy && !clear_q;
    assign issue_rob_id = tail_q;
    assign head_rob_id  = head_q;

    assign query_ready1 = (lsb_ready && lsb_rob_id == query_id1) ||
                          (rs_ready && rs_rob_id == query_id1) || ready_q[query_id1];
    assign query_value1 = (lsb_ready && lsb_rob_id == query_id1) ? lsb_value :
                          (rs_ready && rs_rob_id == query_id1)   ? rs_value  :
                                                                   entry_q[query_id1].value;
    assign query_ready2 = (lsb_ready && lsb_rob_id == query_id2) ||
                          (rs_ready && rs_rob_id == query_id2) || ready_q[query_id2];
    assign query_value2 = (lsb_ready && lsb_rob_id == query_id2) ? lsb_value :
                          (rs_ready && rs_rob_id == query_id2)   ? rs_value  :
                                                                   entry_q[query_id2].value;

    // Pulses are held (not dropped) while rdy is low and masked at the port,
    // so a pending flush is never lost across a stall.
    assign commit_valid  = commit_valid_q && rdy;
    assign commit_store  = commit_store_q && rdy;
    assign rob_clear     = clear_q && rdy;
    assign commit_rd     = commit_rd_q;
    assign commit_value  = commit_value_q;
    assign commit_rob_id = commit_id_q;
    assign clear_pc      = clear_pc_q;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path can infer a latch.
        busy_d         = busy_q;
        ready_d        = ready_q;
        entry_d        = entry_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_valid_d = commit_valid_q;
        commit_store_d = commit_store_q;
        commit_rd_d    = commit_rd_q;
        commit_value_d = commit_value_q;
        commit_id_d    = commit_id_q;
        clear_d        = clear_q;
        clear_pc_d     = clear_pc_q;

        if (rdy) begin
            commit_valid_d = 1'b0;
            commit_store_d = 1'b0;
            clear_d        = 1'b0;

            if (clear_q) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                for (int i = 0; i < ROB_SIZE; i++) begin
                    busy_d[i]  = 1'b0;
                    ready_d[i] = 1'b0;
                end
            end else begin
                for (int i = 0; i < ROB_SIZE; i++) begin
                    if (busy_q[i] && lsb_ready && lsb_rob_id == idx_t'(i)) begin
                        ready_d[i]       = 1'b1;
                        entry_d[i].value = lsb_value;
                    end else if (busy_q[i] && rs_ready && rs_rob_id == idx_t'(i)) begin
                        ready_d[i]       = 1'b1;
                        entry_d[i].value = rs_value;
                    end
                end

                if (retire) begin
                    busy_d[head_q]  = 1'b0;
                    ready_d[head_q] = 1'b0;
                    head_d          = head_q + 1'b1;
                    commit_rd_d     = head_entry.rd;
                    commit_value_d  = head_value;
                    commit_id_d     = head_q;
                    commit_valid_d  = (head_entry.kind == KIND_REG);
                    commit_store_d  = (head_entry.kind == KIND_STORE);
                    if (mispredict) begin
                        clear_d    = 1'b1;
                        clear_pc_d = head_value;
                    end
                end

                if (issue_fire) begin
                    busy_d[tail_q]          = 1'b1;
                    ready_d[tail_q]         = (kind_e'(issue_kind) == KIND_NOP);
                    entry_d[tail_q].kind    = kind_e'(issue_kind);
                    entry_d[tail_q].rd      = issue_rd;
                    entry_d[tail_q].value   = '0;
                    entry_d[tail_q].pred_pc = issue_pred_pc;
                    tail_d                  = tail_q + 1'b1;
                end

                unique case ({issue_fire, retire})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                busy_q[i]  <= 1'b0;
                ready_q[i] <= 1'b0;
            end
            commit_valid_q <= 1'b0;
            commit_store_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            commit_id_q    <= '0;
            clear_q        <= 1'b0;
            clear_pc_q     <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            commit_valid_q <= commit_valid_d;
            commit_store_q <= commit_store_d;
            commit_rd_q    <= commit_rd_d;
            commit_value_q <= commit_value_d;
            commit_id_q    <= commit_id_d;
            clear_q        <= clear_d;
            clear_pc_q     <= clear_pc_d;
        end
    end

    // NOTE: the payload array is deliberately left without reset; busy/ready
    // gate every consumer, so stale contents are never observed.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: scenario tasks with a commit scoreboard queue.
module tb_rob;
    import rob_pkg::*;

    logic        clk, rst, rdy;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [1:0]  issue_kind;
    logic [31:0] issue_pred_pc;
    logic        rob_full;
    logic [2:0]  issue_rob_id;
    logic        rs_ready, lsb_ready;
    logic [2:0]  rs_rob_id, lsb_rob_id;
    logic [31:0] rs_value, lsb_value;
    logic [2:0]  query_id1, query_id2;
    logic        query_ready1, query_ready2;
    logic [31:0] query_value1, query_value2;
    logic        commit_valid, commit_store;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [2:0]  commit_rob_id;
    logic        rob_clear;
    logic [31:0] clear_pc;
    logic [2:0]  head_rob_id;

    typedef struct {
        logic [2:0]  id;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        store;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    rob #(.ROB_SIZE_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_kind(issue_kind),
        .issue_pred_pc(issue_pred_pc), .rob_full(rob_full), .issue_rob_id(issue_rob_id),
        .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
        .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .query_id1(query_id1), .query_id2(query_id2),
        .query_ready1(query_ready1), .query_ready2(query_ready2),
        .query_value1(query_value1), .query_value2(query_value2),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_rob_id(commit_rob_id), .commit_store(commit_store),
        .rob_clear(rob_clear), .clear_pc(clear_pc), .head_rob_id(head_rob_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_rd = '0; issue_kind = '0; issue_pred_pc = '0;
        rs_ready = 1'b0; rs_rob_id = '0; rs_value = '0;
        lsb_ready = 1'b0; lsb_rob_id = '0; lsb_value = '0;
        query_id1 = '0; query_id2 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rdy = 1'b1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        sb_q.delete();
    endtask

    task automatic drive_issue(input kind_e kind, input logic [4:0] rd, input logic [31:0] pc);
        issue_valid = 1'b1; issue_kind = kind; issue_rd = rd; issue_pred_pc = pc;
    endtask

    // Advance one edge; any commit pulse is popped from the scoreboard and compared.
    task automatic sb_step();
        exp_t e;
        tick();
        if (commit_valid || commit_store) begin
            total_cnt++;
            if (sb_q.size() == 0) begin
                $display("FAIL commit_unexpected: got id=%0d rd=%0d val=%h store=%b, none expected",
                         commit_rob_id, commit_rd, commit_value, commit_store);
            end else begin
                e = sb_q.pop_front();
                if ({commit_rob_id, commit_rd, commit_value, commit_store, commit_valid} !==
                    {e.id, e.rd, e.value, e.store, ~e.store})
                    $display("FAIL commit: got id=%0d rd=%0d val=%h st=%b v=%b, want id=%0d rd=%0d val=%h st=%b",
                             commit_rob_id, commit_rd, commit_value, commit_store, commit_valid,
                             e.id, e.rd, e.value, e.store);
                else pass_cnt++;
            end
        end
    endtask

    task automatic expect_drained(input string name);
        total_cnt++;
        if (sb_q.size() != 0) $display("FAIL %s_pending: %0d commits outstanding, want 0", name, sb_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({rob_full, issue_rob_id, head_rob_id, commit_valid, commit_store, rob_clear} !== 9'b0)
            $display("FAIL reset_flags: got full=%b id=%0d head=%0d cv=%b cs=%b clr=%b, want all 0",
                     rob_full, issue_rob_id, head_rob_id, commit_valid, commit_store, rob_clear);
        else pass_cnt++;
        total_cnt++;
        if ({commit_rd, commit_value, clear_pc, commit_rob_id} !== '0)
            $display("FAIL reset_regs: got rd=%0d val=%h pc=%h id=%0d, want 0",
                     commit_rd, commit_value, clear_pc, commit_rob_id);
        else pass_cnt++;
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_issue(KIND_REG, 5'(i + 1), '0);
            total_cnt++;
            if (issue_rob_id !== 3'(i)) $display("FAIL fill_id: got %0d, want %0d", issue_rob_id, i);
            else pass_cnt++;
            sb_q.push_back('{id: 3'(i), rd: 5'(i + 1), value: 32'h1000 + i, store: 1'b0});
            sb_step();
        end
        issue_valid = 1'b0;
        #1;
        total_cnt++;
        if (rob_full !== 1'b1) $display("FAIL fill_full: got %b, want 1", rob_full);
        else pass_cnt++;
        drive_issue(KIND_REG, 5'd9, '0);
        sb_step();
        issue_valid = 1'b0;
        total_cnt++;
        if ({rob_full, issue_rob_id, head_rob_id} !== {1'b1, 3'd0, 3'd0})
            $display("FAIL fill_ignored: got full=%b tail=%0d head=%0d, want 1/0/0",
                     rob_full, issue_rob_id, head_rob_id);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            rs_ready = 1'b1; rs_rob_id = 3'(i); rs_value = 32'h1000 + i;
            sb_step();
        end
        rs_ready = 1'b0;
        repeat (2) sb_step();
        expect_drained("fill");
        total_cnt++;
        if (rob_full !== 1'b0) $display("FAIL fill_empty: got full=%b, want 0", rob_full);
        else pass_cnt++;
    endtask

    task automatic test_out_of_order();
        do_reset();
        drive_issue(KIND_REG, 5'd5, '0);
        sb_q.push_back('{id: 3'd0, rd: 5'd5, value: 32'h11, store: 1'b0});
        sb_step();
        drive_issue(KIND_REG, 5'd6, '0);
        sb_q.push_back('{id: 3'd1, rd: 5'd6, value: 32'h22, store: 1'b0});
        sb_step();
        issue_valid = 1'b0;
        rs_ready = 1'b1; rs_rob_id = 3'd1; rs_value = 32'h22;
        tick();
        total_cnt++;
        if (commit_valid !== 1'b0) $display("FAIL ooo_no_early: got commit_valid=%b, want 0", commit_valid);
        else pass_cnt++;
        rs_rob_id = 3'd0; rs_value = 32'h11;
        sb_step();
        rs_ready = 1'b0;
        sb_step();
        expect_drained("ooo");
    endtask

    task automatic test_forwarding();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_issue(KIND_REG, 5'(10 + i), '0);
            sb_step();
        end
        issue_valid = 1'b0;
        sb_q.push_back('{id: 3'd0, rd: 5'd10, value: 32'h10,   store: 1'b0});
        sb_q.push_back('{id: 3'd1, rd: 5'd11, value: 32'h5555, store: 1'b0});
        sb_q.push_back('{id: 3'd2, rd: 5'd12, value: 32'h7777, store: 1'b0});
        sb_q.push_back('{id: 3'd3, rd: 5'd13, value: 32'hABCD, store: 1'b0});
        query_id1 = 3'd3; query_id2 = 3'd2;
        #1;
        total_cnt++;
        if (query_ready2 !== 1'b0) $display("FAIL fwd_not_ready: got %b, want 0", query_ready2);
        else pass_cnt++;
        rs_ready = 1'b1; rs_rob_id = 3'd3; rs_value = 32'hABCD;
        lsb_ready = 1'b1; lsb_rob_id = 3'd2; lsb_value = 32'h7777;
        #1;
        total_cnt++;
        if ({query_ready1, query_value1} !== {1'b1, 32'hABCD})
            $display("FAIL fwd_rs: got rdy=%b val=%h, want 1/0000abcd", query_ready1, query_value1);
        else pass_cnt++;
        total_cnt++;
        if ({query_ready2, query_value2} !== {1'b1, 32'h7777})
            $display("FAIL fwd_lsb: got rdy=%b val=%h, want 1/00007777", query_ready2, query_value2);
        else pass_cnt++;
        sb_step();
        rs_rob_id = 3'd1; rs_value = 32'h1111;
        lsb_rob_id = 3'd1; lsb_value = 32'h5555;
        query_id1 = 3'd1;
        #1;
        total_cnt++;
        if (query_value1 !== 32'h5555) $display("FAIL fwd_lsb_wins: got %h, want 00005555", query_value1);
        else pass_cnt++;
        sb_step();
        rs_ready = 1'b0; lsb_ready = 1'b0;
        query_id1 = 3'd3;
        #1;
        total_cnt++;
        if ({query_ready1, query_value1, query_ready2, query_value2} !== {1'b1, 32'hABCD, 1'b1, 32'h7777})
            $display("FAIL fwd_stored: got %b/%h %b/%h, want 1/0000abcd 1/00007777",
                     query_ready1, query_value1, query_ready2, query_value2);
        else pass_cnt++;
        query_id1 = 3'd1;
        #1;
        total_cnt++;
        if (query_value1 !== 32'h5555) $display("FAIL fwd_stored_same_id: got %h, want 00005555", query_value1);
        else pass_cnt++;
        rs_ready = 1'b1; rs_rob_id = 3'd0; rs_value = 32'h10;
        sb_step();
        rs_ready = 1'b0;
        repeat (4) sb_step();
        expect_drained("fwd");
    endtask

    task automatic test_mispredict();
        do_reset();
        drive_issue(KIND_BRANCH, 5'd0, 32'h100);
        sb_step();
        drive_issue(KIND_REG, 5'd1, '0);
        sb_step();
        drive_issue(KIND_REG, 5'd2, '0);
        sb_step();
        issue_valid = 1'b0;
        rs_ready = 1'b1; rs_rob_id = 3'd0; rs_value = 32'h200;
        lsb_ready = 1'b1; lsb_rob_id = 3'd1; lsb_value = 32'h99;
        tick();
        rs_ready = 1'b0; lsb_ready = 1'b0;
        total_cnt++;
        if ({rob_clear, clear_pc, commit_valid, commit_store} !== {1'b1, 32'h200, 1'b0, 1'b0})
            $display("FAIL mispredict_flush: got clr=%b pc=%h cv=%b cs=%b, want 1/00000200/0/0",
                     rob_clear, clear_pc, commit_valid, commit_store);
        else pass_cnt++;
        drive_issue(KIND_REG, 5'd3, '0);
        tick();
        issue_valid = 1'b0;
        query_id1 = 3'd1;
        #1;
        total_cnt++;
        if ({rob_clear, rob_full, head_rob_id, issue_rob_id, query_ready1} !== 9'b0)
            $display("FAIL mispredict_after: got clr=%b full=%b head=%0d tail=%0d q1rdy=%b, want all 0",
                     rob_clear, rob_full, head_rob_id, issue_rob_id, query_ready1);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (commit_valid !== 1'b0) $display("FAIL mispredict_ghost: got commit_valid=%b, want 0", commit_valid);
        else pass_cnt++;
        drive_issue(KIND_BRANCH, 5'd0, 32'h300);
        total_cnt++;
        if (issue_rob_id !== 3'd0) $display("FAIL mispredict_next_id: got %0d, want 0", issue_rob_id);
        else pass_cnt++;
        sb_step();
        issue_valid = 1'b0;
        rs_ready = 1'b1; rs_rob_id = 3'd0; rs_value = 32'h300;
        tick();
        rs_ready = 1'b0;
        total_cnt++;
        if ({rob_clear, commit_valid, commit_store, head_rob_id} !== {3'b000, 3'd1})
            $display("FAIL predict_ok: got clr=%b cv=%b cs=%b head=%0d, want 0/0/0/1",
                     rob_clear, commit_valid, commit_store, head_rob_id);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int full_seen;
        full_seen = 0;
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            if (k < 10) begin
                drive_issue((k % 2) ? KIND_STORE : KIND_REG, 5'(k + 1), '0);
                total_cnt++;
                if (issue_rob_id !== 3'(k % 8)) $display("FAIL wrap_id: got %0d, want %0d", issue_rob_id, k % 8);
                else pass_cnt++;
                sb_q.push_back('{id: 3'(k % 8), rd: 5'(k + 1), value: 32'h500 + k, store: 1'((k % 2))});
            end else begin
                issue_valid = 1'b0;
            end
            rs_ready  = (k >= 1);
            rs_rob_id = 3'((k + 7) % 8);
            rs_value  = 32'h500 + k - 1;
            sb_step();
            if (rob_full) full_seen++;
        end
        rs_ready = 1'b0;
        sb_step();
        expect_drained("wrap");
        total_cnt++;
        if ({full_seen, head_rob_id, issue_rob_id} !== {32'd0, 3'd2, 3'd2})
            $display("FAIL wrap_end: got full_seen=%0d head=%0d tail=%0d, want 0/2/2",
                     full_seen, head_rob_id, issue_rob_id);
        else pass_cnt++;
    endtask

    task automatic test_rdy_hold();
        do_reset();
        rdy = 1'b0;
        drive_issue(KIND_REG, 5'd7, '0);
        repeat (2) tick();
        total_cnt++;
        if (issue_rob_id !== 3'd0) $display("FAIL rdy_issue_hold: got %0d, want 0", issue_rob_id);
        else pass_cnt++;
        rdy = 1'b1;
        sb_q.push_back('{id: 3'd0, rd: 5'd7, value: 32'h66, store: 1'b0});
        sb_step();
        issue_valid = 1'b0;
        rdy = 1'b0;
        rs_ready = 1'b1; rs_rob_id = 3'd0; rs_value = 32'h66;
        tick();
        rs_ready = 1'b0;
        rdy = 1'b1;
        #1;
        total_cnt++;
        if ({commit_valid, head_rob_id, issue_rob_id} !== {1'b0, 3'd0, 3'd1})
            $display("FAIL rdy_bcast_hold: got cv=%b head=%0d tail=%0d, want 0/0/1",
                     commit_valid, head_rob_id, issue_rob_id);
        else pass_cnt++;
        sb_step();
        rs_ready = 1'b1;
        sb_step();
        rs_ready = 1'b0;
        sb_step();
        expect_drained("rdy");
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_issue(KIND_REG, 5'(20 + i), '0);
            sb_step();
        end
        issue_valid = 1'b0;
        rs_ready = 1'b1; rs_rob_id = 3'd0; rs_value = 32'h44;
        tick();
        rs_ready = 1'b0;
        total_cnt++;
        if (commit_valid !== 1'b1) $display("FAIL rstmid_inflight: got commit_valid=%b, want 1", commit_valid);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({commit_valid, commit_store, rob_clear, commit_rd, commit_value, commit_rob_id, clear_pc,
             rob_full, head_rob_id, issue_rob_id} !== '0)
            $display("FAIL rstmid_outputs: got cv=%b cs=%b clr=%b rd=%0d val=%h id=%0d pc=%h full=%b head=%0d tail=%0d",
                     commit_valid, commit_store, rob_clear, commit_rd, commit_value, commit_rob_id, clear_pc,
                     rob_full, head_rob_id, issue_rob_id);
        else pass_cnt++;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b1;
        drive_issue(KIND_REG, 5'd30, '0);
        #1;
        total_cnt++;
        if (issue_rob_id !== 3'd0) $display("FAIL rstmid_first_id: got %0d, want 0", issue_rob_id);
        else pass_cnt++;
        sb_step();
        issue_valid = 1'b0;
        total_cnt++;
        if (issue_rob_id !== 3'd1) $display("FAIL rstmid_second_id: got %0d, want 1", issue_rob_id);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        idle_inputs();
        test_reset();
        test_fill();
        test_out_of_order();
        test_forwarding();
        test_mispredict();
        test_wrap();
        test_rdy_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
